// File: rtl/bp_cfg_stream_loader.sv
// Streamed config loader: header, N payload words and an XOR checksum commit one config.
// Define BP_CFG_STREAM_LOADER_TIMEOUT_EN to add a stall watchdog in PAYLOAD/CHECK.
module bp_cfg_stream_loader #(
    parameter int data_width_p  = 32,
    parameter int num_fields_p  = 16,
    parameter int lg_max_cfgs_p = 7,
    parameter int timeout_p     = 256
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 v_i,
    input  logic [data_width_p-1:0]              data_i,
    output logic                                 ready_o,
    output logic [num_fields_p*data_width_p-1:0] cfg_o,
    output logic [lg_max_cfgs_p-1:0]             cfg_id_o,
    output logic                                 cfg_v_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic                                 busy_o
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, RESP} state_e;

    state_e state_q, state_d;

    logic [data_width_p-1:0]  cfg_q    [num_fields_p];
    logic [data_width_p-1:0]  shadow_q [num_fields_p];
    logic [lg_max_cfgs_p-1:0] id_q, cfg_id_q;
    logic [7:0]               n_q, cnt_q;
    logic [data_width_p-1:0]  csum_q;
    logic                     cfg_v_q, ok_q;

    logic       accept, hdr_ok, last_word, timeout;
    logic [7:0] hdr_n;

    assign accept    = v_i & ready_o;
    assign hdr_n     = data_i[23:16];
    assign hdr_ok    = (data_i[7:0] == 8'hA5) && (hdr_n != 8'd0)
                     && (hdr_n <= 8'(num_fields_p));
    assign last_word = (cnt_q == n_q - 8'd1);

    assign ready_o  = (state_q != RESP);
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == RESP) & ok_q;
    assign err_o    = (state_q == RESP) & ~ok_q;
    assign cfg_id_o = cfg_id_q;
    assign cfg_v_o  = cfg_v_q;

    for (genvar k = 0; k < num_fields_p; k++) begin : g_cfg
        assign cfg_o[k*data_width_p +: data_width_p] = cfg_q[k];
    end

`ifdef BP_CFG_STREAM_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(timeout_p + 1);

    logic [WD_W-1:0] wd_q;
    logic            waiting;

    assign waiting = (state_q == PAYLOAD) || (state_q == CHECK);
    assign timeout = waiting && !accept && (wd_q == WD_W'(timeout_p - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || accept || !waiting) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = hdr_ok ? PAYLOAD : RESP;
            PAYLOAD: begin
                if (accept && last_word) state_d = CHECK;
                else if (timeout)        state_d = RESP;
            end
            CHECK:   if (accept || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            id_q     <= '0;
            cfg_id_q <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            cfg_v_q  <= 1'b0;
            ok_q     <= 1'b0;
            for (int k = 0; k < num_fields_p; k++) begin
                cfg_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: if (accept) begin
                    // ok_q stays low until a matching checksum, so
                    // every other exit through RESP reports an error
                    ok_q <= 1'b0;
                    if (hdr_ok) begin
                        id_q   <= data_i[8 +: lg_max_cfgs_p];
                        n_q    <= hdr_n;
                        cnt_q  <= '0;
                        csum_q <= data_i;
                        for (int k = 0; k < num_fields_p; k++)
                            shadow_q[k] <= cfg_q[k];
                    end
                end
                PAYLOAD: if (accept) begin
                    for (int k = 0; k < num_fields_p; k++)
                        if (cnt_q == 8'(k)) shadow_q[k] <= data_i;
                    csum_q <= csum_q ^ data_i;
                    cnt_q  <= cnt_q + 8'd1;
                end
                CHECK: if (accept) begin
                    ok_q <= (data_i == csum_q);
                    if (data_i == csum_q) begin
                        for (int k = 0; k < num_fields_p; k++)
                            cfg_q[k] <= shadow_q[k];
                        cfg_id_q <= id_q;
                        cfg_v_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
